rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Parametrised N-channel, W-bit selector with a registered output and valid/ready handshakes. It is the sequential successor to the bit-level 2:1/4:1 mux tree.
- Merges several operand/result streams onto one datapath, for example ALU/divider result write-back.
- Two selection modes:
  - Fixed select: the channel is chosen by an input.
  - Round-robin arbitration: a rotating-priority pointer chooses the channel.

Parameters:
- WIDTH, 8: data bits per channel.
- CHANNELS, 4: number of input channels, 2..16, not required to be a power of two.
- SEL_W, derived localparam = clog2(CHANNELS): channel-index width. Not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_valid  input  CHANNELS  per-channel valid.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel ready; at most one bit set.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously by design convention):
  - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - A word held in the output register at reset is discarded; no partial transfer.
- load_en = !out_valid || out_ready. The output register accepts a new word when it is empty or being drained in the same cycle.
- Grant (combinational, one-hot or none):
  - mode=0: grant channel sel iff in_valid[sel]=1 and sel<CHANNELS. If sel>=CHANNELS, there is no grant.
  - mode=1: grant the first channel with in_valid=1, searching ptr, ptr+1, ... wrapping modulo CHANNELS. If no valid bits are set, there is no grant.
- in_ready[i] = load_en && grant==i. There is a combinational path out_ready -> in_ready; this is permitted and documented.
- Input transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out_data <= channel i data.
  - out_ch <= i.
  - out_valid <= 1.
- Latency: exactly 1 cycle from input transfer to out_valid=1.
- Throughput: 1 word per cycle while out_ready=1.
- Output transfer: out_valid && out_ready.
  - If there is no simultaneous input transfer, out_valid <= 0.
  - out_data and out_ch hold their last value.
- Simultaneous drain and load in one cycle: the register is overwritten with the new word and out_valid stays 1. No bubble.
- Stall (out_valid=1, out_ready=0):
  - out_data and out_ch are stable.
  - All in_ready=0.
  - ptr is unchanged.
- ptr update:
  - Only on an input transfer with mode=1: ptr <= (granted+1) mod CHANNELS. Wrap from CHANNELS-1 to 0 also applies when CHANNELS is not a power of two.
  - In mode=0 ptr is held.
- Mode or sel changes:
  - Take effect on the grant combinationally in the same cycle.
  - A word already in the output register is unaffected.
  - ptr is kept across mode switches.
- Fairness: in mode=1 with all channels continuously valid and out_ready=1, grants rotate 0,1,...,CHANNELS-1,0. Each channel waits at most CHANNELS-1 grants.
- No data-dependent behaviour: in_data of a non-granted channel never reaches out_data.

Test Plan:
- Reset values: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0x00 and out_ch=0 immediately (before the next clk edge); ptr=0 after release.
- Round-robin, all valid: mode=1, CHANNELS=4, in_valid=4'b1111, data channel i = 0xA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles, out_ch 0,1,2,3,0, one-cycle latency.
- Round-robin skip and wrap: mode=1, ptr=3, in_valid=4'b0101 -> grant ch0, then ch2, then ch0. Channels 1 and 3 are never granted.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0000, ptr unchanged. Release out_ready -> next grant is ptr's channel; no word is lost or duplicated.
- Fixed select: mode=0, sel=2, in_valid=4'b1111 -> only ch2 granted every cycle and out_ch=2. Then in_valid[2]=0 -> in_ready=0000 and out_valid drops after the pending word drains.
- Non-power-of-two wrap: CHANNELS=3, mode=1, all valid -> out_ch 0,1,2,0. With mode=0 and sel=3 -> no grant.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// N-channel registered selector with fixed-select or round-robin arbitration.
// Output register uses a valid/ready handshake; one word per cycle sustained.
module rr_mux_arbiter #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  localparam int KW = SEL_W + 1;
  localparam logic [SEL_W:0]   NCH  = KW'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] ptr_q;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W:0]   idx;
  logic             sel_ok;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;
  logic [SEL_W-1:0] ptr_nxt;

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && gnt_vld;
  assign ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  // Rotating search starts at ptr; index kept one bit wider to wrap mod N.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    sel_ok  = ({1'b0, sel} < NCH);
    if (!mode) begin
      if (sel_ok && in_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = {1'b0, ptr_q} + KW'(k);
        if (idx >= NCH)
          idx = idx - NCH;
        if (!gnt_vld && in_valid[idx[SEL_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer)
      in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (gnt_idx == SEL_W'(i))
        gnt_data = in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr_q     <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt_idx;
      if (mode)
        ptr_q <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
